// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready request and result handshakes
// Define ALU_MC_MUL_EN to build the shift-add multiplier (opcode 101); otherwise 101 is reserved.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             illegal
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
`ifdef ALU_MC_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam int         CW     = $clog2(WIDTH);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef ALU_MC_MUL_EN
    S_MUL  = 2'd1,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t state, state_n;
  logic   illegal_q;
  logic   load_alu;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum;
  logic             is_sub;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;

  // Subtraction reuses the adder as A + ~B + 1, so C reads as "no borrow".
  always_comb begin
    is_sub  = (ALUControl == OP_SUB);
    b_eff   = is_sub ? ~SrcB : SrcB;
    sum     = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND:  alu_res = SrcA & SrcB;
      OP_ORR:  alu_res = SrcA | SrcB;
      OP_EOR:  alu_res = SrcA ^ SrcB;
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [CW-1:0]    mul_cnt;
  logic             mul_last;
  logic             load_mul;
  logic             done_mul;

  assign acc_n    = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (mul_cnt == CW'(WIDTH - 1));

  // One multiplier bit per cycle; the product is truncated to WIDTH bits as it accumulates.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      mul_cnt <= '0;
    end else if (load_mul) begin
      mcand   <= SrcA;
      mplier  <= SrcB;
      acc     <= '0;
      mul_cnt <= '0;
    end else if (state == S_MUL) begin
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      acc     <= acc_n;
      mul_cnt <= mul_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_n  = state;
    load_alu = 1'b0;
`ifdef ALU_MC_MUL_EN
    load_mul = 1'b0;
    done_mul = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef ALU_MC_MUL_EN
          if (ALUControl == OP_MUL) begin
            state_n  = S_MUL;
            load_mul = 1'b1;
          end else
`endif
          begin
            state_n  = S_DONE;
            load_alu = 1'b1;
          end
        end
      end
`ifdef ALU_MC_MUL_EN
      S_MUL: begin
        if (mul_last) begin
          state_n  = S_DONE;
          done_mul = 1'b1;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ALUResult <= '0;
      ALUFlags  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_n;
      if (load_alu) begin
        ALUResult <= alu_res;
        ALUFlags  <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
        illegal_q <= alu_ill;
      end
`ifdef ALU_MC_MUL_EN
      else if (done_mul) begin
        ALUResult <= acc_n;
        ALUFlags  <= {acc_n[WIDTH-1], (acc_n == '0), 2'b00};
        illegal_q <= 1'b0;
      end
`endif
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign illegal   = out_valid & illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc (WIDTH=32) against an arithmetic reference model
// Follows ALU_MC_MUL_EN to choose the expected MUL behaviour.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  ALUControl;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;

  int tests = 0;
  int fails = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .ALUFlags(ALUFlags), .out_valid(out_valid),
    .out_ready(out_ready), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Flags from plain integer arithmetic: unsigned range for C, signed range for V.
  task automatic ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [3:0] f, output logic ill,
                           output int lat);
    longint      sa, sb, s;
    logic [63:0] p;
    logic        c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; ill = 1'b0; lat = 1; r = '0;
    case (op)
      3'd0: begin
        p = {32'd0, a} + {32'd0, b};
        r = p[31:0];
        c = (p > 64'h0000_0000_FFFF_FFFF);
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
`ifdef ALU_MC_MUL_EN
      3'd5: begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0];
        lat = 33;
      end
`endif
      default: ill = 1'b1;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic [3:0]  ef;
    logic        ei;
    int          el;
    int          k;
    logic        seen;
    ref_model(op, a, b, er, ef, ei, el);
    check({tag, "_in_ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1; SrcA = a; SrcB = b; ALUControl = op;
    out_ready = (hold == 0);
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (out_valid) begin
        seen = 1'b1;
        in_valid = 1'b0;
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        SrcA = $urandom; SrcB = $urandom; ALUControl = 3'($urandom_range(0, 7));
      end
    end
    in_valid = 1'b0;
    check({tag, "_seen"}, seen, 1'b1);
    check({tag, "_latency"}, k, el);
    check({tag, "_result"}, ALUResult, er);
    check({tag, "_flags"}, ALUFlags, ef);
    check({tag, "_illegal"}, illegal, ei);
    check({tag, "_in_ready_done"}, in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_result"}, ALUResult, er);
      check({tag, "_hold_flags"}, ALUFlags, ef);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_after_valid"}, out_valid, 1'b0);
    check({tag, "_after_illegal"}, illegal, 1'b0);
    check({tag, "_after_in_ready"}, in_ready, 1'b1);
    check({tag, "_after_result"}, ALUResult, er);
    check({tag, "_after_flags"}, ALUFlags, ef);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_0000};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic       spurious;
    logic [2:0] rop;
    reset = 1'b1; in_valid = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_result", ALUResult, 32'd0);
    check("rst_flags", ALUFlags, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_illegal", illegal, 1'b0);

    do_op("add_4_5", 3'd0, 32'h4, 32'h5, 0);
    do_op("sub_4_5", 3'd1, 32'h4, 32'h5, 0);
    do_op("sub_5_5", 3'd1, 32'h5, 32'h5, 0);
    do_op("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h1, 0);
    do_op("add_carry", 3'd0, 32'hFFFF_FFFF, 32'h1, 0);
    do_op("and", 3'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
    do_op("orr", 3'd3, 32'hF000_0000, 32'h0000_000F, 0);
    do_op("eor", 3'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0);
    do_op("mul_7_6", 3'd5, 32'h7, 32'h6, 0);
    do_op("mul_wrap", 3'd5, 32'h0001_0000, 32'h0001_0000, 0);
    do_op("rsv_6", 3'd6, 32'h1234, 32'h5678, 0);
    do_op("rsv_7", 3'd7, 32'hFFFF_FFFF, 32'h1, 0);
    do_op("hold5", 3'd0, 32'h8000_0000, 32'h8000_0000, 5);
    do_op("after_hold", 3'd1, 32'h0, 32'h1, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      do_op("rand", rop, pick_operand(), pick_operand(), (n % 7 == 3) ? 2 : 0);
    end

    // Abort an operation in flight: MUL when built, otherwise a result parked in DONE.
    in_valid = 1'b1; SrcA = 32'h3; SrcB = 32'h4;
`ifdef ALU_MC_MUL_EN
    ALUControl = 3'd5; out_ready = 1'b1;
`else
    ALUControl = 3'd0; out_ready = 1'b0;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    check("abort_result", ALUResult, 32'd0);
    check("abort_flags", ALUFlags, 4'b0000);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_illegal", illegal, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    spurious = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) spurious = 1'b1;
    end
    check("abort_no_out_valid", spurious, 1'b0);
    do_op("post_abort_add", 3'd0, 32'h4, 32'h5, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
